// File: rtl/fir_filter_tdm.sv
// NTAPS-tap signed FIR evaluated through a single time-multiplexed MAC.
// Samples enter on a valid/ready handshake; each result is shifted, saturated and strobed once.
module fir_filter_tdm #(
    parameter int COEFF_W   = 8,
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 32,
    parameter int NTAPS     = 8,
    parameter int SHIFT     = 0,
    parameter int COEFF_RST = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic signed [COEFF_W-1:0] coef_wdata,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic signed [DATA_W-1:0]  sample_T,
    output logic                      busy
);

    localparam int ACC_W  = DATA_W + COEFF_W + $clog2(NTAPS);
    localparam int TAP_W  = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);
    localparam logic [TAP_W:0]   NTAPS_V  = (TAP_W + 1)'(NTAPS);

    // Handshake: a sample transfers on a rising CLK edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and out_valid is a one-cycle strobe with no backpressure.
    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   x_q [NTAPS];
    logic signed [DATA_W-1:0]   x_d [NTAPS];
    logic signed [COEFF_W-1:0]  coef_q [NTAPS];
    logic signed [COEFF_W-1:0]  coef_d [NTAPS];
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]    out_data_q, out_data_d;
    logic                       out_sat_q, out_sat_d;

    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    final_acc;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [OUT_W-1:0]    sat_data;
    logic                       sat_flag;
    logic                       coef_addr_ok;

    // The final tap's product is folded in combinationally so the result registers on that edge.
    assign prod      = PROD_W'(coef_q[tap_q]) * PROD_W'(x_q[tap_q]);
    assign final_acc = acc_q + ACC_W'(prod);
    assign shifted   = final_acc >>> SHIFT;

    generate
        if (OUT_W >= ACC_W) begin : g_no_sat
            assign sat_data = OUT_W'(shifted);
            assign sat_flag = 1'b0;
        end else begin : g_sat
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
            always_comb begin
                sat_flag = 1'b0;
                sat_data = shifted[OUT_W-1:0];
                if (shifted > SAT_MAX) begin
                    sat_flag = 1'b1;
                    sat_data = SAT_MAX[OUT_W-1:0];
                end else if (shifted < SAT_MIN) begin
                    sat_flag = 1'b1;
                    sat_data = SAT_MIN[OUT_W-1:0];
                end
            end
        end
    endgenerate

    assign coef_addr_ok = ({1'b0, coef_addr} < NTAPS_V);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        coef_d      = coef_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            IDLE: begin
                if (coef_we && coef_addr_ok) begin
                    coef_d[coef_addr] = coef_wdata;
                end
                if (in_valid) begin
                    for (int k = 1; k < NTAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0]  = in_data;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = final_acc;
                if (tap_q == TAP_LAST) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sat_data;
                    out_sat_d   = sat_flag;
                    tap_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= COEFF_W'(COEFF_RST);
            end
            acc_q       <= '0;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MAC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sample_T  = x_q[0];

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed bench for fir_filter_tdm: default 32-bit instance plus a 16-bit saturating instance.
module tb_fir_filter_tdm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [7:0]  coef_wdata;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               out_sat;
    logic signed [15:0] sample_t;
    logic               busy;

    logic               s_in_valid;
    logic               s_in_ready;
    logic signed [15:0] s_in_data;
    logic               s_coef_we;
    logic [2:0]         s_coef_addr;
    logic signed [7:0]  s_coef_wdata;
    logic               s_out_valid;
    logic signed [15:0] s_out_data;
    logic               s_out_sat;
    logic signed [15:0] s_sample_t;
    logic               s_busy;

    fir_filter_tdm dut (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
        .sample_T(sample_t), .busy(busy)
    );

    fir_filter_tdm #(.OUT_W(16), .SHIFT(0)) dut_s (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_wdata(s_coef_wdata),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_sat(s_out_sat),
        .sample_T(s_sample_t), .busy(s_busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        s_in_valid = 1'b0; s_in_data = '0;
        s_coef_we = 1'b0; s_coef_addr = '0; s_coef_wdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic signed [15:0] d);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready got=%b exp=1 after %0d cycles", in_ready, waited);
        end
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [7:0] v);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // lat counts negedges from the accept cycle; -1 means no strobe within the budget.
    task automatic wait_result(output logic signed [31:0] d, output logic s, output int lat);
        lat = -1; d = '0; s = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                d = out_data; s = out_sat; lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'sd0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        total++; if (sample_t !== 16'sd0) begin bad++; $display("FAIL reset_sample_T got=%0d exp=0", sample_t); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_impulse();
        logic signed [31:0] d;
        logic s;
        int lat;
        logic signed [31:0] exp_d;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send((k == 0) ? 16'sd100 : 16'sd0);
            if (k == 0) begin
                total++; if (sample_t !== 16'sd100) begin bad++; $display("FAIL impulse_sample_T got=%0d exp=100", sample_t); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL impulse_busy got=%b exp=1", busy); end
            end
            wait_result(d, s, lat);
            exp_d = (k < 8) ? 32'sd1600 : 32'sd0;
            total++; if (lat != 9) begin bad++; $display("FAIL impulse_latency k=%0d got=%0d exp=9", k, lat); end
            total++; if (d !== exp_d) begin bad++; $display("FAIL impulse_data k=%0d got=%0d exp=%0d", k, d, exp_d); end
            total++; if (s !== 1'b0) begin bad++; $display("FAIL impulse_sat k=%0d got=%b exp=0", k, s); end
            if (k == 0) begin
                @(negedge clk);
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL impulse_strobe_width got=%b exp=0", out_valid); end
                total++; if (out_data !== 32'sd1600) begin bad++; $display("FAIL impulse_hold got=%0d exp=1600", out_data); end
            end
        end
    endtask

    task automatic test_step();
        logic signed [31:0] d;
        logic s;
        int lat;
        logic signed [31:0] exp_d;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            send(16'sd1000);
            wait_result(d, s, lat);
            exp_d = 32'sd16000 * ((k < 8) ? k : 8);
            total++; if (lat != 9) begin bad++; $display("FAIL step_latency k=%0d got=%0d exp=9", k, lat); end
            total++; if (d !== exp_d) begin bad++; $display("FAIL step_data k=%0d got=%0d exp=%0d", k, d, exp_d); end
        end
    endtask

    task automatic test_coef_load();
        logic signed [31:0] d;
        logic s;
        int lat;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 8'(k + 1));
        for (int k = 0; k < 8; k++) begin
            send((k == 0) ? 16'sd1 : 16'sd0);
            wait_result(d, s, lat);
            total++; if (d !== 32'(k + 1)) begin bad++; $display("FAIL coef_impulse k=%0d got=%0d exp=%0d", k, d, k + 1); end
        end
        // delay line is now [0..0,1]; accepting 1 gives [1,0,..]
        send(16'sd1);
        write_coef(3'd0, 8'sd100);
        wait_result(d, s, lat);
        total++; if (d !== 32'sd1) begin bad++; $display("FAIL coef_mac_write_cur got=%0d exp=1", d); end
        send(16'sd1);
        wait_result(d, s, lat);
        total++; if (d !== 32'sd3) begin bad++; $display("FAIL coef_mac_write_next got=%0d exp=3", d); end
        // write and accept in the same IDLE cycle: x=[2,1,1,0..], coef0=5 -> 10+2+3
        in_valid = 1'b1; in_data = 16'sd2;
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'sd5;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
        wait_result(d, s, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL coef_same_cycle_latency got=%0d exp=9", lat); end
        total++; if (d !== 32'sd15) begin bad++; $display("FAIL coef_same_cycle got=%0d exp=15", d); end
    endtask

    task automatic test_signed_extremes();
        logic signed [31:0] d;
        logic s;
        int lat;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), -8'sd128);
        send(-16'sd32768);
        wait_result(d, s, lat);
        total++; if (d !== 32'sd4194304) begin bad++; $display("FAIL extremes_data got=%0d exp=4194304", d); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL extremes_sat got=%b exp=0", s); end
    endtask

    task automatic test_saturation();
        int strobes = 0;
        logic signed [15:0] last_d = '0;
        logic last_s = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            s_coef_we = 1'b1; s_coef_addr = 3'(k); s_coef_wdata = 8'sd127;
            @(posedge clk); #1;
        end
        s_coef_we = 1'b0;
        s_in_valid = 1'b1; s_in_data = 16'sd32767;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_out_valid) begin strobes++; last_d = s_out_data; last_s = s_out_sat; end
        end
        total++; if (strobes != 11) begin bad++; $display("FAIL sat_strobes got=%0d exp=11", strobes); end
        total++; if (last_d !== 16'sh7fff) begin bad++; $display("FAIL sat_pos_data got=%0d exp=32767", last_d); end
        total++; if (last_s !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b exp=1", last_s); end
        s_in_data = -16'sd32768;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_out_valid) begin last_d = s_out_data; last_s = s_out_sat; end
        end
        s_in_valid = 1'b0;
        total++; if (last_d !== 16'sh8000) begin bad++; $display("FAIL sat_neg_data got=%0d exp=-32768", last_d); end
        total++; if (last_s !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b exp=1", last_s); end
    endtask

    task automatic test_back_to_back();
        int low = 0;
        int strobes = 0;
        do_reset();
        in_valid = 1'b1; in_data = 16'sd0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (!in_ready) low++;
            if (out_valid) strobes++;
        end
        in_valid = 1'b0;
        total++; if (low != 24) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=24", low); end
        total++; if (strobes != 2) begin bad++; $display("FAIL b2b_strobes got=%0d exp=2", strobes); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [31:0] d;
        logic s;
        int lat;
        int strobes = 0;
        do_reset();
        write_coef(3'd0, 8'sd3);
        send(16'sd500);
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'sd0) begin bad++; $display("FAIL rmid_out_data got=%0d exp=0", out_data); end
        total++; if (sample_t !== 16'sd0) begin bad++; $display("FAIL rmid_sample_T got=%0d exp=0", sample_t); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) strobes++;
        end
        total++; if (strobes != 0) begin bad++; $display("FAIL rmid_aborted_strobe got=%0d exp=0", strobes); end
        send(16'sd100);
        wait_result(d, s, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL rmid_after_latency got=%0d exp=9", lat); end
        total++; if (d !== 32'sd1600) begin bad++; $display("FAIL rmid_after_data got=%0d exp=1600", d); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_coef_load();
        test_signed_extremes();
        test_saturation();
        test_back_to_back();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_filter_tdm.md
Name: fir_filter_tdm

Overview:
Parametrised successor to the team's fixed 8-tap direct-form FIR. It computes an NTAPS-tap signed FIR through one time-multiplexed multiply-accumulate unit. Coefficients are runtime-programmable, and the block uses a valid/ready input handshake, an output valid strobe, arithmetic right-shift scaling and saturation. It sits in the same sample-processing chain, between the sample source and downstream consumers.

Parameters:
COEFF_W, 8, coefficient word width (signed)
DATA_W, 16, input sample width (signed)
OUT_W, 32, output width (signed)
NTAPS, 8, number of taps (>=2)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
COEFF_RST, 16, value loaded into every coefficient at reset
ACC_W, DATA_W+COEFF_W+$clog2(NTAPS), accumulator width (derived; not overridden)

Ports:
CLK  in  1  clock
RST_N  in  1  reset; one clock, synchronous, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
coef_we  in  1  coefficient write enable
coef_addr  in  $clog2(NTAPS)  tap index to write
coef_wdata  in  COEFF_W  signed coefficient value
out_valid  out  1  one-cycle strobe: new result on out_data
out_data  out  OUT_W  signed filtered result; held between strobes
out_sat  out  1  result was clamped; qualified by out_valid, held with out_data
sample_T  out  DATA_W  newest sample in the delay line, x[0]
busy  out  1  FSM is in MAC

Behaviour:
- Reset (RST_N=0 at a CLK edge) has these effects:
  - state IDLE; delay line x[0..NTAPS-1]=0; all coefficients=COEFF_RST; accumulator and tap counter cleared.
  - out_valid=0, out_data=0, out_sat=0, sample_T=0, busy=0, in_ready=1 in the first cycle after reset.
- Reset mid-MAC aborts the computation. No out_valid is produced for the aborted sample.
- FSM has two states: IDLE and MAC.
  - IDLE: in_ready=1, busy=0.
    - On in_valid&&in_ready: shift x[k]<=x[k-1] and x[0]<=in_data; clear acc; tap<=0; go to MAC.
  - MAC: in_ready=0, busy=1.
    - Each cycle: acc<=acc+coef[tap]*x[tap] (full-precision signed product, sign-extended to ACC_W); tap<=tap+1.
    - On the cycle with tap==NTAPS-1, the final product is added combinationally and the result is registered: out_data<=sat(final_acc>>>SHIFT), out_valid<=1, out_sat updated, state<=IDLE.
- Latency: sample accepted at edge E0 gives out_valid=1 in the cycle after edge E_NTAPS. That is the same cycle in_ready returns to 1.
- Throughput: one sample per NTAPS+1 cycles. With in_valid held high, the block accepts a sample every NTAPS+1 cycles. in_data is sampled only on acceptance.
- out_valid is high for exactly one cycle per result. Downstream has no backpressure; a result not taken is overwritten by the next one.
- Saturation: the shifted accumulator is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and out_sat=1 when clamping occurred. If OUT_W>=ACC_W-SHIFT, the result is sign-extended and out_sat is always 0.
- Coefficient writes:
  - Honoured only in IDLE and take effect at the next edge.
  - Ignored in MAC, so a result always uses one coherent coefficient set.
  - A write in the same IDLE cycle as a sample acceptance is honoured and applies to that sample's computation.
- sample_T updates on acceptance only.
- Arithmetic is signed throughout. The tap counter never exceeds NTAPS-1.

Test Plan:
- Impulse, default coefs: in_data=100 then 0s -> 8 results of 1600, then 0. out_valid arrives exactly 9 cycles after each accept.
- Step: in_data=1000 held -> outputs 16000, 32000, …, 128000, then steady at 128000.
- Coef load: write coef[k]=k+1 in IDLE, then impulse 1 -> outputs 1,2,…,8. A write issued during MAC must leave the next result unchanged.
- Signed extremes: all coefs=-128, single sample -32768 -> first output 4194304, out_sat=0.
- Saturation: OUT_W=16, SHIFT=0, coefs=127, in_data=32767 held -> out_data settles at 32767 with out_sat=1. With in_data=-32768 held -> out_data=-32768, out_sat=1.
- Handshake and reset: in_valid held high -> in_ready low for 8 of every 9 cycles. Deasserting RST_N mid-MAC -> no out_valid, all outputs 0, coefficients back to 16, in_ready=1 next cycle.
